// File: rtl/puf_crp_collector_if.sv
// Signal bundle between a sweep controller, the PUF under test and the CRP sink.
// The slave modport is the collector's view; master is the surrounding environment.
interface puf_crp_collector_if;
    logic       start;
    logic [7:0] chall_first;
    logic [7:0] chall_last;

    logic       puf_en;
    logic       puf_rst;
    logic [7:0] puf_chall;
    logic [7:0] puf_response;
    logic       puf_ready;

    logic       crp_valid;
    logic       crp_ready;
    logic [7:0] crp_chall;
    logic [7:0] crp_resp;
    logic       crp_err;

    logic       busy;
    logic       done;
    logic       err_seen;
    logic [8:0] crp_count;

    modport master (
        output start, chall_first, chall_last,
        output puf_response, puf_ready,
        output crp_ready,
        input  puf_en, puf_rst, puf_chall,
        input  crp_valid, crp_chall, crp_resp, crp_err,
        input  busy, done, err_seen, crp_count
    );

    modport slave (
        input  start, chall_first, chall_last,
        input  puf_response, puf_ready,
        input  crp_ready,
        output puf_en, puf_rst, puf_chall,
        output crp_valid, crp_chall, crp_resp, crp_err,
        output busy, done, err_seen, crp_count
    );
endinterface

// File: rtl/puf_crp_collector.sv
// Sweeps a range of 8-bit challenges through a PUF and streams challenge/response
// records downstream, substituting an error record when the PUF does not answer.
module puf_crp_collector #(
    parameter int RST_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    puf_crp_collector_if.slave   bus
);

    localparam logic [3:0]  RST_LAST     = 4'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRST,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t      state_reg,    state_next;
    logic [7:0]  chall_reg,    chall_next;
    logic [7:0]  end_reg,      end_next;
    logic [3:0]  rst_cnt_reg,  rst_cnt_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [7:0]  resp_reg,     resp_next;
    logic        err_reg,      err_next;
    logic        err_seen_reg, err_seen_next;
    logic [8:0]  count_reg,    count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            chall_reg    <= 8'h00;
            end_reg      <= 8'h00;
            rst_cnt_reg  <= 4'd0;
            wait_cnt_reg <= 16'd0;
            resp_reg     <= 8'h00;
            err_reg      <= 1'b0;
            err_seen_reg <= 1'b0;
            count_reg    <= 9'd0;
        end else begin
            state_reg    <= state_next;
            chall_reg    <= chall_next;
            end_reg      <= end_next;
            rst_cnt_reg  <= rst_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            resp_reg     <= resp_next;
            err_reg      <= err_next;
            err_seen_reg <= err_seen_next;
            count_reg    <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        chall_next    = chall_reg;
        end_next      = end_reg;
        rst_cnt_next  = rst_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        resp_next     = resp_reg;
        err_next      = err_reg;
        err_seen_next = err_seen_reg;
        count_next    = count_reg;

        bus.puf_en    = 1'b0;
        bus.puf_rst   = 1'b0;
        bus.crp_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    chall_next    = bus.chall_first;
                    end_next      = bus.chall_last;
                    count_next    = 9'd0;
                    err_seen_next = 1'b0;
                    rst_cnt_next  = 4'd0;
                    state_next    = ST_PRST;
                end
            end

            ST_PRST: begin
                bus.puf_en  = 1'b1;
                bus.puf_rst = 1'b1;
                if (rst_cnt_reg == RST_LAST) begin
                    rst_cnt_next  = 4'd0;
                    wait_cnt_next = 16'd0;
                    state_next    = ST_WAIT;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 4'd1;
                end
            end

            ST_WAIT: begin
                bus.puf_en = 1'b1;
                // The first WAIT cycle is a settle cycle; ready is tested ahead of
                // the timeout so a response on the final cycle still counts.
                if (wait_cnt_reg != 16'd0 && bus.puf_ready) begin
                    resp_next  = bus.puf_response;
                    err_next   = 1'b0;
                    state_next = ST_EMIT;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    resp_next     = 8'h00;
                    err_next      = 1'b1;
                    err_seen_next = 1'b1;
                    state_next    = ST_EMIT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end

            ST_EMIT: begin
                bus.puf_en    = 1'b1;
                bus.crp_valid = 1'b1;
                if (bus.crp_ready) begin
                    count_next = count_reg + 9'd1;
                    if (chall_reg == end_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        chall_next   = chall_reg + 8'd1;
                        rst_cnt_next = 4'd0;
                        state_next   = ST_PRST;
                    end
                end
            end

            ST_DONE: begin
                bus.done   = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The record challenge is the live challenge register: it only moves on the
    // EMIT handshake, so it is stable for as long as the record is offered.
    assign bus.puf_chall = chall_reg;
    assign bus.crp_chall = chall_reg;
    assign bus.crp_resp  = resp_reg;
    assign bus.crp_err   = err_reg;
    assign bus.err_seen  = err_seen_reg;
    assign bus.crp_count = count_reg;

endmodule

// File: tb/tb_puf_crp_collector.sv
// Directed bench for puf_crp_collector with a behavioural PUF
// (response = challenge ^ 8'hA5, ready a programmable number of cycles after reset).
module tb_puf_crp_collector;

    localparam int TO = 16;

    logic clk;
    logic rst;
    puf_crp_collector_if bus ();

    puf_crp_collector #(
        .RST_CYCLES    (1),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] r;
        logic       e;
    } rec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    rec_t recs[$];
    int   done_cnt = 0;
    int   wait_seen = 0;
    logic [7:0] watch_chall = 8'h00;

    // PUF model controls
    int         since = 0;
    int         ready_delay = 3;
    bit         block_en = 1'b0;
    logic [7:0] block_chall = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.puf_rst)
            since <= 0;
        else if (since < 100000)
            since <= since + 1;
    end

    assign bus.puf_response = bus.puf_chall ^ 8'hA5;
    assign bus.puf_ready    = bus.puf_en && !bus.puf_rst && (since >= ready_delay)
                              && !(block_en && bus.puf_chall == block_chall);

    // Record sink, done counter and WAIT-cycle counter for a watched challenge
    always @(negedge clk) begin
        if (!rst && bus.crp_valid && bus.crp_ready) begin
            recs.push_back({bus.crp_chall, bus.crp_resp, bus.crp_err});
            $display("record chall=%02h resp=%02h err=%0d count_before=%0d",
                     bus.crp_chall, bus.crp_resp, bus.crp_err, bus.crp_count);
        end
        if (!rst && bus.done)
            done_cnt = done_cnt + 1;
        if (!rst && bus.puf_en && !bus.puf_rst && !bus.crp_valid && bus.puf_chall == watch_chall)
            wait_seen = wait_seen + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs(input logic [7:0] watch);
        recs.delete();
        done_cnt    = 0;
        wait_seen   = 0;
        watch_chall = watch;
    endtask

    task automatic start_sweep(input logic [7:0] f, input logic [7:0] l);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.chall_first = f;
        bus.chall_last  = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_vec++;
        if ({bus.puf_en, bus.puf_rst, bus.crp_valid, bus.crp_err, bus.busy, bus.done, bus.err_seen} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got en/rst/valid/err/busy/done/seen=%b expected 0000000",
                     {bus.puf_en, bus.puf_rst, bus.crp_valid, bus.crp_err, bus.busy, bus.done, bus.err_seen});
        end
        n_vec++;
        if ({bus.puf_chall, bus.crp_chall, bus.crp_resp} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_data: got puf_chall=%h crp_chall=%h crp_resp=%h expected all 00",
                     bus.puf_chall, bus.crp_chall, bus.crp_resp);
        end
        n_vec++;
        if (bus.crp_count !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d expected 0", bus.crp_count);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        bit ok;
        rec_t exp_r[3];
        exp_r[0] = {8'h01, 8'hA4, 1'b0};
        exp_r[1] = {8'h02, 8'hA7, 1'b0};
        exp_r[2] = {8'h03, 8'hA6, 1'b0};
        clear_obs(8'h01);
        start_sweep(8'h01, 8'h03);
        wait_done(200, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic_done_timeout: got no done within 200 cycles expected done");
        end
        tick(4);
        n_vec++;
        if (recs.size() != 3) begin
            n_bad++;
            $display("FAIL basic_rec_count: got %0d records expected 3", recs.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (recs[i] !== exp_r[i]) begin
                n_bad++;
                $display("FAIL basic_rec%0d: got %h expected %h", i, recs[i], exp_r[i]);
            end
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt);
        end
        n_vec++;
        if ({bus.crp_count, bus.err_seen, bus.busy} !== {9'd3, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_idle_status: got count=%0d err_seen=%0d busy=%0d expected 3 0 0",
                     bus.crp_count, bus.err_seen, bus.busy);
        end
        // PUF answers on the 4th WAIT cycle with the default model delay
        n_vec++;
        if (wait_seen != 4) begin
            n_bad++;
            $display("FAIL basic_wait_cycles: got %0d expected 4", wait_seen);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [7:0] exp_c[4];
        exp_c[0] = 8'hFE; exp_c[1] = 8'hFF; exp_c[2] = 8'h00; exp_c[3] = 8'h01;
        clear_obs(8'h00);
        start_sweep(8'hFE, 8'h01);
        wait_done(300, ok);
        tick(2);
        n_vec++;
        if (!ok || recs.size() != 4 || bus.crp_count !== 9'd4) begin
            n_bad++;
            $display("FAIL wrap_totals: got done=%0d records=%0d count=%0d expected 1 4 4",
                     ok, recs.size(), bus.crp_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (recs[i] !== {exp_c[i], exp_c[i] ^ 8'hA5, 1'b0}) begin
                n_bad++;
                $display("FAIL wrap_rec%0d: got %h expected %h", i, recs[i], {exp_c[i], exp_c[i] ^ 8'hA5, 1'b0});
            end
        end
    endtask

    task automatic test_single;
        bit ok;
        clear_obs(8'h42);
        start_sweep(8'h42, 8'h42);
        wait_done(100, ok);
        tick(2);
        n_vec++;
        if (!ok || recs.size() != 1 || recs[0] !== {8'h42, 8'hE7, 1'b0} || bus.crp_count !== 9'd1) begin
            n_bad++;
            $display("FAIL single: got done=%0d records=%0d rec0=%h count=%0d expected 1 1 42e70 1",
                     ok, recs.size(), recs[0], bus.crp_count);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        // Challenge 0x05 never answers
        block_en    = 1'b1;
        block_chall = 8'h05;
        clear_obs(8'h05);
        start_sweep(8'h04, 8'h06);
        wait_done(300, ok);
        tick(2);
        block_en = 1'b0;
        n_vec++;
        if (!ok || recs.size() != 3) begin
            n_bad++;
            $display("FAIL timeout_totals: got done=%0d records=%0d expected 1 3", ok, recs.size());
        end
        n_vec++;
        if (recs[0] !== {8'h04, 8'hA1, 1'b0} || recs[2] !== {8'h06, 8'hA3, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_neighbours: got %h %h expected 04a10 06a30", recs[0], recs[2]);
        end
        n_vec++;
        if (recs[1] !== {8'h05, 8'h00, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_record: got %h expected 05001", recs[1]);
        end
        n_vec++;
        if (wait_seen != TO) begin
            n_bad++;
            $display("FAIL timeout_wait_cycles: got %0d expected %0d", wait_seen, TO);
        end
        n_vec++;
        if (bus.err_seen !== 1'b1 || bus.crp_count !== 9'd3) begin
            n_bad++;
            $display("FAIL timeout_status: got err_seen=%0d count=%0d expected 1 3", bus.err_seen, bus.crp_count);
        end

        // Ready arrives on the very last WAIT cycle: the response wins
        ready_delay = TO - 1;
        clear_obs(8'h07);
        start_sweep(8'h07, 8'h07);
        wait_done(100, ok);
        tick(2);
        n_vec++;
        if (recs[0] !== {8'h07, 8'hA2, 1'b0} || wait_seen != TO || bus.err_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_vs_timeout: got rec=%h wait=%0d err_seen=%0d expected 07a20 %0d 0",
                     recs[0], wait_seen, bus.err_seen, TO);
        end

        // One cycle later is too late
        ready_delay = TO;
        clear_obs(8'h07);
        start_sweep(8'h07, 8'h07);
        wait_done(100, ok);
        tick(2);
        n_vec++;
        if (recs[0] !== {8'h07, 8'h00, 1'b1} || bus.err_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL late_ready: got rec=%h err_seen=%0d expected 07001 1", recs[0], bus.err_seen);
        end

        // Ready already high in the settle cycle must be ignored there
        ready_delay = 0;
        clear_obs(8'h50);
        start_sweep(8'h50, 8'h50);
        wait_done(100, ok);
        tick(2);
        n_vec++;
        if (recs[0] !== {8'h50, 8'hF5, 1'b0} || wait_seen != 2) begin
            n_bad++;
            $display("FAIL settle_cycle: got rec=%h wait=%0d expected 50f50 2", recs[0], wait_seen);
        end
        ready_delay = 3;
    endtask

    task automatic test_backpressure;
        bit ok;
        bit seen;
        logic [24:0] held;
        bus.crp_ready = 1'b0;
        clear_obs(8'h10);
        start_sweep(8'h10, 8'h11);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.crp_valid) seen = 1'b1;
        end
        held = {bus.crp_valid, bus.crp_chall, bus.crp_resp, bus.crp_err, bus.puf_chall[6:0]};
        n_vec++;
        if (!seen || held !== {1'b1, 8'h10, 8'hB5, 1'b0, 7'h10}) begin
            n_bad++;
            $display("FAIL bp_first_offer: got %h expected %h", held, {1'b1, 8'h10, 8'hB5, 1'b0, 7'h10});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.crp_valid, bus.crp_chall, bus.crp_resp, bus.crp_err, bus.puf_chall[6:0]} !== held
                || bus.puf_chall !== 8'h10) begin
                n_bad++;
                $display("FAIL bp_hold_cycle%0d: got valid=%0d chall=%h resp=%h err=%0d puf_chall=%h expected 1 10 b5 0 10",
                         i, bus.crp_valid, bus.crp_chall, bus.crp_resp, bus.crp_err, bus.puf_chall);
            end
        end
        bus.crp_ready = 1'b1;
        wait_done(100, ok);
        tick(2);
        n_vec++;
        if (!ok || recs.size() != 2 || recs[0] !== {8'h10, 8'hB5, 1'b0}
            || recs[1] !== {8'h11, 8'hB4, 1'b0} || bus.crp_count !== 9'd2) begin
            n_bad++;
            $display("FAIL bp_records: got done=%0d n=%0d r0=%h r1=%h count=%0d expected 1 2 10b50 11b40 2",
                     ok, recs.size(), recs[0], recs[1], bus.crp_count);
        end
    endtask

    task automatic test_rst_midsweep;
        bit ok;
        bit hit;
        clear_obs(8'h21);
        start_sweep(8'h20, 8'h22);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (bus.puf_chall == 8'h21 && bus.puf_en && !bus.puf_rst && !bus.crp_valid) hit = 1'b1;
        end
        n_vec++;
        if (!hit) begin
            n_bad++;
            $display("FAIL rst_reach_wait: got no WAIT on challenge 21 expected one within 100 cycles");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.puf_en, bus.puf_rst, bus.crp_valid, bus.crp_err, bus.busy, bus.done, bus.err_seen,
             bus.puf_chall, bus.crp_chall, bus.crp_resp, bus.crp_count} !== 40'h0) begin
            n_bad++;
            $display("FAIL rst_midsweep_outputs: got en=%0d prst=%0d valid=%0d err=%0d busy=%0d done=%0d seen=%0d pch=%h cch=%h resp=%h count=%0d expected all 0",
                     bus.puf_en, bus.puf_rst, bus.crp_valid, bus.crp_err, bus.busy, bus.done, bus.err_seen,
                     bus.puf_chall, bus.crp_chall, bus.crp_resp, bus.crp_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        clear_obs(8'h21);
        start_sweep(8'h20, 8'h22);
        wait_done(200, ok);
        tick(2);
        n_vec++;
        if (!ok || recs.size() != 3 || recs[0] !== {8'h20, 8'h85, 1'b0} || recs[1] !== {8'h21, 8'h84, 1'b0}
            || recs[2] !== {8'h22, 8'h87, 1'b0} || bus.crp_count !== 9'd3) begin
            n_bad++;
            $display("FAIL rst_resweep: got done=%0d n=%0d r0=%h r1=%h r2=%h count=%0d expected 1 3 20850 21840 22870 3",
                     ok, recs.size(), recs[0], recs[1], recs[2], bus.crp_count);
        end
    endtask

    task automatic test_start_ignored;
        bit ok;
        clear_obs(8'h80);
        start_sweep(8'h30, 8'h32);
        tick(2);
        start_sweep(8'h80, 8'h80);
        wait_done(200, ok);
        tick(4);
        n_vec++;
        if (!ok || recs.size() != 3 || recs[0][16:9] !== 8'h30 || recs[1][16:9] !== 8'h31
            || recs[2][16:9] !== 8'h32) begin
            n_bad++;
            $display("FAIL start_ignored_records: got done=%0d n=%0d c0=%h c1=%h c2=%h expected 1 3 30 31 32",
                     ok, recs.size(), recs[0][16:9], recs[1][16:9], recs[2][16:9]);
        end
        n_vec++;
        if (bus.crp_count !== 9'd3 || done_cnt != 1 || bus.busy !== 1'b0 || wait_seen != 0) begin
            n_bad++;
            $display("FAIL start_ignored_status: got count=%0d dones=%0d busy=%0d wait80=%0d expected 3 1 0 0",
                     bus.crp_count, done_cnt, bus.busy, wait_seen);
        end
    endtask

    task automatic test_full_range;
        bit ok;
        int bad_recs;
        clear_obs(8'h00);
        start_sweep(8'h00, 8'hFF);
        wait_done(5000, ok);
        tick(2);
        n_vec++;
        if (!ok || recs.size() != 256 || bus.crp_count !== 9'd256 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL full_range_totals: got done=%0d n=%0d count=%0d dones=%0d expected 1 256 256 1",
                     ok, recs.size(), bus.crp_count, done_cnt);
        end
        bad_recs = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = 8'(i);
            n_vec++;
            if (recs[i] !== {c, c ^ 8'hA5, 1'b0}) begin
                n_bad++;
                bad_recs++;
                if (bad_recs <= 4)
                    $display("FAIL full_range_rec%0d: got %h expected %h", i, recs[i], {c, c ^ 8'hA5, 1'b0});
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.chall_first = 8'h00;
        bus.chall_last  = 8'h00;
        bus.crp_ready   = 1'b1;

        test_reset;
        test_basic;
        test_wrap;
        test_single;
        test_timeout;
        test_backpressure;
        test_rst_midsweep;
        test_start_ignored;
        test_full_range;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
